spi_reg_write_sequencer: RTL and testbench

SPI controller that configures the SPI register peripheral. It takes register write commands (7-bit address, 8-bit data) from on-chip logic through a valid/ready interface and buffers them in a small FIFO. Each command is serialized as one 16-bit SPI mode-0 write frame on sclk/ncs/copi. The block is the bring-up and test driver for the output-enable, PWM-enable and PWM duty-cycle registers.

---
 rtl/spi_reg_write_sequencer_if.sv | 10 +
 rtl/spi_reg_write_sequencer.sv | 162 ++++++++++++++++
 tb/tb_spi_reg_write_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_write_sequencer_if.sv
// Register-write command channel (7-bit address, 8-bit data) with valid/ready handshake.
interface spi_reg_write_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_addr, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_addr, input cmd_data, output cmd_ready);
endinterface

// File: rtl/spi_reg_write_sequencer.sv
// Buffers register writes in a small FIFO and sends each as a 16-bit SPI mode-0 frame; ncs falls 2 cycles after a push into an idle block.
// cmd_ready drops while the FIFO is full; a pop in the same cycle frees the slot only from the next cycle.
module spi_reg_write_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  spi_reg_write_sequencer_if.slave    cmd,
  output logic                        sclk,
  output logic                        ncs,
  output logic                        copi,
  output logic                        busy,
  output logic [7:0]                  frames_sent
);

  localparam int         AW          = $clog2(FIFO_DEPTH);
  localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD  = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t state, state_nxt;

  logic [14:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, push, pop;

  logic [15:0] shreg, shreg_nxt;
  logic [7:0]  hcnt, hcnt_nxt;
  logic [3:0]  bit_cnt, bit_nxt;
  logic        sclk_nxt, ncs_nxt, copi_nxt;
  logic [7:0]  frames_nxt;
  logic        phase_done;

  assign fifo_full     = (fifo_cnt == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty    = (fifo_cnt == '0);
  assign cmd.cmd_ready = rst_n && !fifo_full;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = rst_n && ((state != IDLE) || !fifo_empty);
  assign phase_done    = (hcnt == 8'd0);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd.cmd_addr, cmd.cmd_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    shreg_nxt  = shreg;
    hcnt_nxt   = hcnt;
    bit_nxt    = bit_cnt;
    sclk_nxt   = sclk;
    ncs_nxt    = ncs;
    copi_nxt   = copi;
    frames_nxt = frames_sent;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_nxt = {1'b1, fifo_mem[rd_ptr]};
          ncs_nxt   = 1'b0;
          copi_nxt  = 1'b1;
          sclk_nxt  = 1'b0;
          hcnt_nxt  = HALF_RELOAD;
          bit_nxt   = 4'd0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (phase_done) begin
          sclk_nxt  = 1'b1;
          hcnt_nxt  = HALF_RELOAD;
          state_nxt = SHIFT;
        end else begin
          hcnt_nxt = hcnt - 8'd1;
        end
      end
      SHIFT: begin
        if (!phase_done) begin
          hcnt_nxt = hcnt - 8'd1;
        end else begin
          hcnt_nxt = HALF_RELOAD;
          if (sclk) begin
            sclk_nxt = 1'b0;
            bit_nxt  = bit_cnt + 4'd1;
            // The 16th falling edge keeps bit0 on copi; its low phase is the hold time.
            if (bit_cnt == 4'd15) begin
              state_nxt = HOLD;
            end else begin
              copi_nxt  = shreg[14];
              shreg_nxt = {shreg[14:0], 1'b0};
            end
          end else begin
            sclk_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (phase_done) begin
          ncs_nxt    = 1'b1;
          copi_nxt   = 1'b0;
          frames_nxt = frames_sent + 8'd1;
          hcnt_nxt   = GAP_RELOAD;
          state_nxt  = GAP;
        end else begin
          hcnt_nxt = hcnt - 8'd1;
        end
      end
      GAP: begin
        if (phase_done) state_nxt = IDLE;
        else            hcnt_nxt  = hcnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg       <= '0;
      hcnt        <= '0;
      bit_cnt     <= '0;
      sclk        <= 1'b0;
      ncs         <= 1'b1;
      copi        <= 1'b0;
      frames_sent <= '0;
    end else begin
      shreg       <= shreg_nxt;
      hcnt        <= hcnt_nxt;
      bit_cnt     <= bit_nxt;
      sclk        <= sclk_nxt;
      ncs         <= ncs_nxt;
      copi        <= copi_nxt;
      frames_sent <= frames_nxt;
    end
  end

endmodule

// File: tb/tb_spi_reg_write_sequencer.sv
// Bench for spi_reg_write_sequencer: DUT 0 at CLK_DIV=4, DUT 1 at CLK_DIV=2 feeding a register-file model.
module tb_spi_reg_write_sequencer;
  localparam int D0 = 4;
  localparam int D1 = 2;
  localparam int GAP = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_reg_write_sequencer_if if0();
  spi_reg_write_sequencer_if if1();

  logic [1:0]      sclk_v, ncs_v, copi_v, busy_v;
  logic [1:0][7:0] fs_v;

  spi_reg_write_sequencer #(.CLK_DIV(D0), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd(if0), .sclk(sclk_v[0]), .ncs(ncs_v[0]),
    .copi(copi_v[0]), .busy(busy_v[0]), .frames_sent(fs_v[0]));

  spi_reg_write_sequencer #(.CLK_DIV(D1), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd(if1), .sclk(sclk_v[1]), .ncs(ncs_v[1]),
    .copi(copi_v[1]), .busy(busy_v[1]), .frames_sent(fs_v[1]));

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          gap_q0[$];

  logic [1:0]  prev_sclk = 2'b00;
  logic [1:0]  prev_ncs = 2'b11;
  int          rise_cnt[2];
  int          low_cnt[2];
  int          high_cnt[2];
  int          sclk_rises[2];
  logic [15:0] cap[2];
  logic [7:0]  fmodel[2];
  logic [7:0]  preg[128];

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] word;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic frame_done(input int d);
    logic [15:0] w;
    check("frame_bits", 32'(rise_cnt[d]), 32'd16);
    check("ncs_low_cycles", 32'(low_cnt[d]), 32'(33 * (d == 0 ? D0 : D1)));
    if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      fail_now("unexpected_frame");
    end else begin
      w = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check("frame_word", 32'(cap[d]), 32'(w));
    end
    fmodel[d] = fmodel[d] + 8'd1;
    check("frames_sent_track", 32'(fs_v[d]), 32'(fmodel[d]));
    if (d == 1 && cap[d][15]) preg[cap[d][14:8]] = cap[d][7:0];
  endtask

  task automatic mon_step(input int d);
    if (!rst_n) begin
      rise_cnt[d] = 0; low_cnt[d] = 0; high_cnt[d] = 0;
      cap[d] = '0; fmodel[d] = '0;
      if (d == 1) for (int i = 0; i < 128; i++) preg[i] = 8'h00;
    end else begin
      if (ncs_v[d]) begin
        if (!prev_ncs[d]) begin
          frame_done(d);
          high_cnt[d] = 0;
        end
        high_cnt[d]++;
      end else begin
        if (prev_ncs[d]) begin
          if (d == 0) gap_q0.push_back(high_cnt[0]);
          low_cnt[d] = 0; rise_cnt[d] = 0; cap[d] = '0;
        end
        low_cnt[d]++;
      end
      if (!prev_sclk[d] && sclk_v[d]) begin
        sclk_rises[d]++;
        if (!ncs_v[d]) begin
          cap[d] = {cap[d][14:0], copi_v[d]};
          rise_cnt[d]++;
        end
      end
    end
    prev_sclk[d] = sclk_v[d];
    prev_ncs[d] = ncs_v[d];
  endtask

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  task automatic drive(input int d, input logic v, input logic [6:0] a, input logic [7:0] dt);
    if (d == 0) begin
      if0.cmd_valid = v; if0.cmd_addr = a; if0.cmd_data = dt;
    end else begin
      if1.cmd_valid = v; if1.cmd_addr = a; if1.cmd_data = dt;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? if0.cmd_ready : if1.cmd_ready;
  endfunction

  // Presents a command and returns once it is certain to be taken at the coming edge.
  task automatic send(input int d, input logic [6:0] a, input logic [7:0] dt,
                      input logic [15:0] w, output int stalls, output int t_acc);
    stalls = 0;
    @(negedge clk);
    drive(d, 1'b1, a, dt);
    #1;
    while (!rdy(d) && stalls < 2000) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    t_acc = cyc;
    if (rdy(d)) begin
      if (d == 0) exp_q0.push_back(w);
      else        exp_q1.push_back(w);
    end else begin
      fail_now("send_timeout");
    end
  endtask

  task automatic idle_in(input int d);
    @(negedge clk);
    drive(d, 1'b0, 7'h00, 8'h00);
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_v[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_v[d]) fail_now("wait_idle_timeout");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 7'h00, 8'h00);
    drive(1, 1'b0, 7'h00, 8'h00);
    repeat (2) @(negedge clk);
    exp_q0.delete();
    exp_q1.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, ta, n, last_low, snap;
    int stl[6];
    logic [6:0] a;
    logic [7:0] dt;

    tbl[0] = '{7'h04, 8'hA5, 16'h84A5};
    tbl[1] = '{7'h00, 8'hFF, 16'h80FF};
    tbl[2] = '{7'h01, 8'h0F, 16'h810F};
    tbl[3] = '{7'h02, 8'h3C, 16'h823C};
    tbl[4] = '{7'h03, 8'h00, 16'h8300};

    drive(0, 1'b0, 7'h00, 8'h00);
    drive(1, 1'b0, 7'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk_v[0]), 32'd0);
    check("rst_ncs", 32'(ncs_v[0]), 32'd1);
    check("rst_copi", 32'(copi_v[0]), 32'd0);
    check("rst_frames", 32'(fs_v[0]), 32'd0);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_ready", 32'(if0.cmd_ready), 32'd0);
    rst_n = 1'b1;

    // Single write: latency, frame content and busy tail.
    send(0, tbl[0].addr, tbl[0].data, tbl[0].word, st, ta);
    idle_in(0);
    n = 0;
    while (ncs_v[0] && n < 100) begin @(negedge clk); n++; end
    check("ncs_fall_latency", 32'(cyc - ta), 32'd2);
    last_low = cyc;
    n = 0;
    while (busy_v[0] && n < 1000) begin
      @(negedge clk);
      if (!ncs_v[0]) last_low = cyc;
      n++;
    end
    check("busy_tail", 32'(cyc - last_low), 32'(GAP + 1));
    check("single_frames", 32'(fs_v[0]), 32'd1);
    check("single_queue_empty", 32'(exp_q0.size()), 32'd0);

    // Back-to-back writes from the table.
    do_reset();
    gap_q0.delete();
    for (int i = 1; i < 5; i++) begin
      send(0, tbl[i].addr, tbl[i].data, tbl[i].word, st, ta);
      check("b2b_ready_held", 32'(st), 32'd0);
    end
    idle_in(0);
    wait_idle(0, 2000);
    check("b2b_frames", 32'(fs_v[0]), 32'd4);
    check("b2b_gap_count", 32'(gap_q0.size()), 32'd4);
    if (gap_q0.size() == 4)
      for (int i = 1; i < 4; i++) check("b2b_gap", 32'(gap_q0[i]), 32'(GAP + 1));

    // Full FIFO with cmd_valid held high.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      a = 7'h10 + 7'(i);
      dt = 8'(i * 37 + 5);
      send(0, a, dt, {1'b1, a, dt}, stl[i], ta);
    end
    idle_in(0);
    check("full_first5_no_stall", 32'(stl[0] + stl[1] + stl[2] + stl[3] + stl[4]), 32'd0);
    // Sixth waits from the edge after the 5th push until one edge past the second pop.
    check("full_sixth_stall", 32'(stl[5]), 32'(33 * D0 + GAP + 1 - 3));
    wait_idle(0, 2000);
    check("full_frames", 32'(fs_v[0]), 32'd6);
    check("full_queue_empty", 32'(exp_q0.size()), 32'd0);

    // Reset in the middle of a frame.
    do_reset();
    send(0, 7'h05, 8'h5A, 16'h855A, st, ta);
    send(0, 7'h06, 8'h66, 16'h8666, st, ta);
    idle_in(0);
    n = 0;
    while (rise_cnt[0] < 7 && n < 500) begin @(negedge clk); n++; end
    check("midreset_reached_7", 32'(rise_cnt[0]), 32'd7);
    rst_n = 1'b0;
    exp_q0.delete();
    @(negedge clk);
    check("midreset_ncs", 32'(ncs_v[0]), 32'd1);
    check("midreset_sclk", 32'(sclk_v[0]), 32'd0);
    check("midreset_copi", 32'(copi_v[0]), 32'd0);
    check("midreset_frames", 32'(fs_v[0]), 32'd0);
    check("midreset_busy", 32'(busy_v[0]), 32'd0);
    check("midreset_ready", 32'(if0.cmd_ready), 32'd0);
    rst_n = 1'b1;
    snap = sclk_rises[0];
    repeat (60) @(negedge clk);
    check("postreset_no_sclk", 32'(sclk_rises[0] - snap), 32'd0);
    check("postreset_busy", 32'(busy_v[0]), 32'd0);
    check("postreset_ncs", 32'(ncs_v[0]), 32'd1);

    // Register-file integration at CLK_DIV=2.
    send(1, 7'h04, 8'h80, 16'h8480, st, ta);
    send(1, 7'h00, 8'h01, 16'h8001, st, ta);
    idle_in(1);
    wait_idle(1, 1000);
    check("periph_pwm_duty", 32'(preg[4]), 32'h80);
    check("periph_en_out", 32'(preg[0]), 32'h01);
    for (int i = 1; i < 4; i++) check("periph_untouched", 32'(preg[i]), 32'h00);
    check("periph_frames", 32'(fs_v[1]), 32'd2);

    // frames_sent wrap.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      a = 7'(i);
      dt = 8'(i ^ 8'h5C);
      send(1, a, dt, {1'b1, a, dt}, st, ta);
    end
    idle_in(1);
    wait_idle(1, 2000);
    check("wrap_255", 32'(fs_v[1]), 32'hFF);
    send(1, 7'h7F, 8'hC3, 16'hFFC3, st, ta);
    idle_in(1);
    wait_idle(1, 1000);
    check("wrap_256", 32'(fs_v[1]), 32'h00);
    check("wrap_queue_empty", 32'(exp_q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
